lc_transition_initiator: RTL and testbench
==========================================

# lc_transition_initiator

Requester side of the lifecycle transition handshake. Accepts a host command naming a target lifecycle state. Walks the lifecycle protection block one state at a time: for each step it fetches an identifier from a host stream, holds `lc_transition_request`/`lc_identifier` until the responder answers or a timeout expires, then releases the request. It sits between the host/boot controller and the lifecycle protection block and reports completion, progress and failure cause.

## Interface
- `ID_WIDTH`, 256, identifier width
- `LC_WIDTH`, 3, lifecycle state width
- `LC_END`, 5, end-of-life state; no transition out of it
- `TIMEOUT`, 16, cycles to wait for `lc_success` after request assertion
- `GUARD`, 2, idle cycles after request release before the next request

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-low
- `cmd_valid` in 1: host command valid
- `cmd_ready` out 1: high only in IDLE
- `cmd_target` in LC_WIDTH: requested final lifecycle state
- `id_valid` in 1: identifier stream valid
- `id_ready` out 1: high only in FETCH_ID
- `id_data` in ID_WIDTH: identifier for the current step
- `lc_transition_request` out 1: to protection block
- `lc_identifier` out ID_WIDTH: to protection block
- `lc_success` in 1: from protection block
- `lc_state` in LC_WIDTH: from protection block
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse at command completion
- `error` out 1: valid with `done`; sticky until next command accepted
- `err_code` out 2: 0 NONE, 1 BAD_TARGET, 2 AUTH_FAIL, 3 STATE_MISMATCH; sticky like `error`
- `steps_done` out LC_WIDTH: successful transitions in the current command

## Operation
- States: IDLE, FETCH_ID, REQ, WAIT_ACK, RELEASE, GUARD_WAIT, DONE.
- IDLE, on `cmd_valid`:
  - latch target; clear `error`, `err_code`, `steps_done`
  - if `cmd_target <= lc_state` or `cmd_target > LC_END`: err BAD_TARGET, go to DONE, no request issued
  - else go to FETCH_ID
- FETCH_ID: on `id_valid & id_ready`, latch `id_data` and `lc_state` as `prev_lc`; go to REQ.
- REQ: assert `lc_transition_request`; drive the latched identifier; clear timer; go to WAIT_ACK. The request and identifier stay stable until RELEASE.
- WAIT_ACK: timer increments each cycle.
  - `lc_success` high and `lc_state == prev_lc+1`: increment `steps_done`, go to RELEASE (ok).
  - `lc_success` high and `lc_state != prev_lc+1`: STATE_MISMATCH, go to RELEASE (err).
  - timer reaches TIMEOUT with no success: AUTH_FAIL, go to RELEASE (err).
  - success takes priority if it arrives in the same cycle as the timeout.
- RELEASE: deassert request; wait until `lc_success` is low; go to GUARD_WAIT.
- GUARD_WAIT: count GUARD cycles, then:
  - on error, or when `lc_state == target`: go to DONE
  - otherwise: go to FETCH_ID
- DONE: pulse `done`; return to IDLE.
- `cmd_valid` is ignored while busy. `id_valid` outside FETCH_ID is ignored.
- Reset mid-operation: all state is cleared immediately and the request drops. The responder recovers on its own reset.

## Timing
- Reset values:
  - `cmd_ready` = 1; all other outputs 0
  - `lc_identifier` = 0; FSM in IDLE
- All outputs are registered.
- Request rises 2 cycles after the id handshake (FETCH_ID→REQ→output).
- A failed step ends `TIMEOUT+1` cycles after the request rises, plus the release and GUARD cycles.
- Minimum request-low time between steps is GUARD+1 cycles.
- BAD_TARGET: `done` is asserted 2 cycles after the command handshake.

## Configuration
- `LC_INIT_ID_SCRUB_EN` defined:
  - `lc_identifier` is forced to 0 whenever the request is low
  - the internal identifier register is zeroed on entry to RELEASE and on reset
- Undefined:
  - `lc_identifier` holds the last latched identifier until it is overwritten
  - the register is not cleared

## Structure
- Shared package `lc_pkg`:
  - FSM state enum
  - `err_code` enum
  - `LC_END`, `LC_WIDTH` constants (shared with the protection block)
- One sub-module, `lc_step_timer`: a loadable up-counter with `clear`, `en` and a `hit` output, instantiated once for both TIMEOUT and GUARD counts.

## Test plan
- `lc_state`=0, target=2, responder accepts both ids → two requests, `steps_done`=2, `done` with `error`=0, `lc_state`=2.
- `lc_state`=3, target=2 → BAD_TARGET, `done` 2 cycles after the command, request never asserted.
- Wrong identifier (responder never succeeds) → request held 16 cycles, then dropped; AUTH_FAIL; `steps_done`=0.
- Responder asserts success with `lc_state` unchanged → STATE_MISMATCH, request released, `done`, `error`=1.
- Success and timeout in the same cycle → success wins; next step is fetched.
- `rst` low during WAIT_ACK → request and `lc_identifier` 0 in the same cycle; `cmd_ready`=1 after release; with the macro defined, `lc_identifier`=0 between steps.

Source files
------------

// File: rtl/lc_pkg.sv
// Shared lifecycle definitions: state width, end-of-life state, initiator FSM
// states and failure causes.
package lc_pkg;

  localparam int unsigned LC_WIDTH = 3;
  localparam logic [LC_WIDTH-1:0] LC_END = LC_WIDTH'(5);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH_ID   = 3'd1,
    ST_REQ        = 3'd2,
    ST_WAIT_ACK   = 3'd3,
    ST_RELEASE    = 3'd4,
    ST_GUARD_WAIT = 3'd5,
    ST_DONE       = 3'd6
  } lc_init_state_e;

  typedef enum logic [1:0] {
    ERR_NONE           = 2'd0,
    ERR_BAD_TARGET     = 2'd1,
    ERR_AUTH_FAIL      = 2'd2,
    ERR_STATE_MISMATCH = 2'd3
  } lc_err_e;

endpackage

// File: rtl/lc_step_timer.sv
// Loadable up-counter: clear zeroes the count and loads the limit; hit is a
// registered flag that is high whenever the count equals the loaded limit.
module lc_step_timer #(
  parameter int unsigned CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic                 hit
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] lim_q, lim_d;

  // Next count and limit: clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    lim_d = lim_q;
    if (clear) begin
      cnt_d = '0;
      lim_d = limit;
    end else if (en) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Count/limit registers; hit is precomputed so it lines up with the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      lim_q <= '1;
      hit   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
      hit   <= (cnt_d == lim_d);
    end
  end

endmodule

// File: rtl/lc_transition_initiator.sv
// Requester side of the lifecycle transition handshake. Steps the protection
// block one lifecycle state at a time toward a host-requested target.
// Optional build macro LC_INIT_ID_SCRUB_EN: the identifier output reads zero
// whenever the request is low, and the stored identifier is wiped on release.
module lc_transition_initiator
  import lc_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 256,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned GUARD    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LC_WIDTH-1:0] cmd_target,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ID_WIDTH-1:0] id_data,
  output logic                lc_transition_request,
  output logic [ID_WIDTH-1:0] lc_identifier,
  input  logic                lc_success,
  input  logic [LC_WIDTH-1:0] lc_state,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [LC_WIDTH-1:0] steps_done
);

  localparam int unsigned TMR_MAX = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LIM = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GUARD_LIM   = TMR_W'(GUARD - 1);

  lc_init_state_e      state_q, state_d;
  logic [LC_WIDTH-1:0] target_q;
  logic [LC_WIDTH-1:0] prev_lc_q;
  logic [ID_WIDTH-1:0] id_q;

  logic                tmr_clear, tmr_en, tmr_hit;
  logic [TMR_W-1:0]    tmr_limit;
  logic                accept_cmd, bad_target, take_id, step_ok, step_err;
  lc_err_e             step_code;

  lc_step_timer #(.CNT_WIDTH(TMR_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .en    (tmr_en),
    .limit (tmr_limit),
    .hit   (tmr_hit)
  );

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_d    = state_q;
    tmr_clear  = 1'b0;
    tmr_en     = 1'b0;
    tmr_limit  = TIMEOUT_LIM;
    accept_cmd = 1'b0;
    bad_target = 1'b0;
    take_id    = 1'b0;
    step_ok    = 1'b0;
    step_err   = 1'b0;
    step_code  = ERR_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept_cmd = 1'b1;
          if ((cmd_target <= lc_state) || (cmd_target > LC_END)) begin
            bad_target = 1'b1;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_FETCH_ID;
          end
        end
      end
      ST_FETCH_ID: begin
        if (id_valid && id_ready) begin
          take_id = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        tmr_clear = 1'b1;
        tmr_limit = TIMEOUT_LIM;
        state_d   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        tmr_en = 1'b1;
        if (lc_success) begin
          state_d = ST_RELEASE;
          if (lc_state == LC_WIDTH'(prev_lc_q + LC_WIDTH'(1))) begin
            step_ok = 1'b1;
          end else begin
            step_err  = 1'b1;
            step_code = ERR_STATE_MISMATCH;
          end
        end else if (tmr_hit) begin
          step_err  = 1'b1;
          step_code = ERR_AUTH_FAIL;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!lc_success) begin
          tmr_clear = 1'b1;
          tmr_limit = GUARD_LIM;
          state_d   = ST_GUARD_WAIT;
        end
      end
      ST_GUARD_WAIT: begin
        tmr_en    = 1'b1;
        tmr_limit = GUARD_LIM;
        if (tmr_hit) begin
          state_d = (error || (lc_state == target_q)) ? ST_DONE : ST_FETCH_ID;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q               <= ST_IDLE;
      target_q              <= '0;
      prev_lc_q             <= '0;
      id_q                  <= '0;
      cmd_ready             <= 1'b1;
      id_ready              <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      lc_transition_request <= 1'b0;
      error                 <= 1'b0;
      err_code              <= ERR_NONE;
      steps_done            <= '0;
    end else begin
      state_q               <= state_d;
      cmd_ready             <= (state_d == ST_IDLE);
      id_ready              <= (state_d == ST_FETCH_ID);
      busy                  <= (state_d != ST_IDLE);
      lc_transition_request <= (state_d == ST_WAIT_ACK);
      done                  <= (state_q == ST_DONE);
      if (accept_cmd) begin
        target_q   <= cmd_target;
        error      <= bad_target;
        err_code   <= bad_target ? ERR_BAD_TARGET : ERR_NONE;
        steps_done <= '0;
      end
      if (take_id) begin
        id_q      <= id_data;
        prev_lc_q <= lc_state;
      end
      if (step_ok) begin
        steps_done <= steps_done + LC_WIDTH'(1);
      end
      if (step_err) begin
        error    <= 1'b1;
        err_code <= step_code;
      end
`ifdef LC_INIT_ID_SCRUB_EN
      if ((state_q == ST_WAIT_ACK) && (state_d == ST_RELEASE)) begin
        id_q <= '0;
      end
`endif
    end
  end

`ifdef LC_INIT_ID_SCRUB_EN
  logic [ID_WIDTH-1:0] ident_q;

  // Identifier output is only non-zero while the request is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ident_q <= '0;
    end else begin
      ident_q <= (state_d == ST_WAIT_ACK) ? id_q : '0;
    end
  end

  assign lc_identifier = ident_q;
`else
  assign lc_identifier = id_q;
`endif

endmodule

// File: tb/tb_lc_transition_initiator.sv
// Scoreboard bench for lc_transition_initiator: a behavioural responder plays
// the protection block, an id source feeds identifiers, and monitors check
// request/identifier behaviour and command completion against queued
// expectations.
module tb_lc_transition_initiator;

  localparam int M_ACCEPT   = 0;
  localparam int M_NEVER    = 1;
  localparam int M_NOCHANGE = 2;

  typedef struct packed {
    logic       err;
    logic [1:0] code;
    logic [2:0] steps;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_target = 3'd0;
  logic         id_valid;
  logic         id_ready;
  logic [255:0] id_data;
  logic         lc_transition_request;
  logic [255:0] lc_identifier;
  logic         lc_success;
  logic [2:0]   lc_st = 3'd0;
  logic         busy, done, error;
  logic [1:0]   err_code;
  logic [2:0]   steps_done;

  int errors = 0;
  int checks = 0;
  int mode = M_ACCEPT;
  int resp_delay = 0;
  int req_cnt = 0;
  int done_cnt = 0;

  exp_t         sb[$];
  int           exp_len[$];
  logic [255:0] exp_id[$];

  lc_transition_initiator dut (
    .clk                   (clk),
    .rst                   (rst),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_target            (cmd_target),
    .id_valid              (id_valid),
    .id_ready              (id_ready),
    .id_data               (id_data),
    .lc_transition_request (lc_transition_request),
    .lc_identifier         (lc_identifier),
    .lc_success            (lc_success),
    .lc_state              (lc_st),
    .busy                  (busy),
    .done                  (done),
    .error                 (error),
    .err_code              (err_code),
    .steps_done            (steps_done)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] make_id(input int unsigned n);
    return {8{32'hC0DE_0000 + 32'(n)}};
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_id(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Identifier source: always valid, advances after every accepted id.
  initial begin
    int unsigned n;
    n = 1;
    id_valid = 1'b1;
    id_data  = make_id(n);
    forever begin
      @(negedge clk);
      if (rst && id_ready) begin
        exp_id.push_back(id_data);
        @(posedge clk);
        #1;
        n++;
        id_data = make_id(n);
      end
    end
  end

  // Responder model of the protection block.
  initial begin
    lc_success = 1'b0;
    forever begin
      @(posedge lc_transition_request);
      if (mode != M_NEVER) begin
        repeat (resp_delay) @(posedge clk);
        #1;
        if (mode == M_ACCEPT) lc_st = lc_st + 3'd1;
        lc_success = 1'b1;
        while (lc_transition_request) begin
          @(posedge clk);
          #1;
        end
        lc_success = 1'b0;
      end
    end
  end

  // Monitor: request width, identifier, inter-request gap and completion.
  initial begin
    logic         req_prev;
    logic         gap_valid;
    int           req_len;
    int           gap_len;
    logic [255:0] last_id;
    exp_t         e;
    req_prev = 1'b0; gap_valid = 1'b0; req_len = 0; gap_len = 0; last_id = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        req_prev  = 1'b0;
        gap_valid = 1'b0;
        req_len   = 0;
        gap_len   = 0;
      end else begin
        if (lc_transition_request) begin
          if (!req_prev) begin
            req_cnt++;
            if (exp_id.size() == 0) begin
              check("req_without_id", 1, 0);
            end else begin
              last_id = exp_id.pop_front();
              check_id("req_identifier", lc_identifier, last_id);
            end
            if (gap_valid) check("req_low_gap_ok", int'(gap_len >= 3), 1);
            req_len = 0;
          end
          req_len++;
        end else begin
          if (req_prev) begin
            if (exp_len.size() == 0) check("unexpected_req", req_len, 0);
            else check("req_high_cycles", req_len, exp_len.pop_front());
`ifdef LC_INIT_ID_SCRUB_EN
            check_id("id_after_release", lc_identifier, '0);
`else
            check_id("id_after_release", lc_identifier, last_id);
`endif
            gap_len   = 0;
            gap_valid = 1'b1;
          end
          gap_len++;
`ifdef LC_INIT_ID_SCRUB_EN
          check_id("id_scrubbed_low", lc_identifier, '0);
`endif
        end
        if (done) begin
          done_cnt++;
          gap_valid = 1'b0;
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("done_error", int'(error), int'(e.err));
            check("done_err_code", int'(err_code), int'(e.code));
            check("done_steps", int'(steps_done), int'(e.steps));
          end
        end
        req_prev = lc_transition_request;
      end
    end
  end

  task automatic setup(input logic [2:0] st, input int m, input int d);
    @(negedge clk);
    lc_st      = st;
    mode       = m;
    resp_delay = d;
  endtask

  // Issue one command and wait (bounded) for done; returns done latency.
  task automatic run_cmd(input logic [2:0] tgt, input exp_t e, output int lat);
    int  start;
    bit  seen;
    sb.push_back(e);
    start = done_cnt;
    @(negedge clk);
    cmd_target = tgt;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 600 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != start) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      void'(sb.pop_back());
    end
  endtask

  initial begin
    int lat;
    int rc;
    bit seen;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_req", int'(lc_transition_request), 0);
    check_id("rst_identifier", lc_identifier, '0);
    check("rst_error", int'(error), 0);
    check("rst_steps", int'(steps_done), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_cmd_ready", int'(cmd_ready), 1);
    check("idle_id_ready", int'(id_ready), 0);
    check("idle_done", int'(done), 0);
    check("idle_err_code", int'(err_code), 0);

    // Two successful steps 0 -> 2.
    setup(3'd0, M_ACCEPT, 3);
    exp_len.push_back(4); exp_len.push_back(4);
    rc = req_cnt;
    run_cmd(3'd2, '{err: 1'b0, code: 2'd0, steps: 3'd2}, lat);
    check("two_step_reqs", req_cnt - rc, 2);
    check("two_step_steps_held", int'(steps_done), 2);

    // Target not above current state.
    setup(3'd3, M_ACCEPT, 0);
    rc = req_cnt;
    run_cmd(3'd2, '{err: 1'b1, code: 2'd1, steps: 3'd0}, lat);
    check("bad_target_latency", lat, 2);
    check("bad_target_no_req", req_cnt - rc, 0);

    // Target beyond end-of-life.
    setup(3'd0, M_ACCEPT, 0);
    rc = req_cnt;
    run_cmd(3'd6, '{err: 1'b1, code: 2'd1, steps: 3'd0}, lat);
    check("beyond_end_latency", lat, 2);
    check("beyond_end_no_req", req_cnt - rc, 0);

    // Single step into end-of-life with immediate answer.
    setup(3'd4, M_ACCEPT, 0);
    exp_len.push_back(1);
    run_cmd(3'd5, '{err: 1'b0, code: 2'd0, steps: 3'd1}, lat);

    // Responder never answers: timeout.
    setup(3'd0, M_NEVER, 0);
    exp_len.push_back(16);
    rc = req_cnt;
    run_cmd(3'd1, '{err: 1'b1, code: 2'd2, steps: 3'd0}, lat);
    check("auth_fail_reqs", req_cnt - rc, 1);

    // Success without a state change.
    setup(3'd1, M_NOCHANGE, 2);
    exp_len.push_back(3);
    run_cmd(3'd3, '{err: 1'b1, code: 2'd3, steps: 3'd0}, lat);
    repeat (3) @(negedge clk);
    check("mismatch_error_sticky", int'(error), 1);
    check("mismatch_code_sticky", int'(err_code), 3);

    // Success arriving in the timeout cycle wins, both steps.
    setup(3'd0, M_ACCEPT, 15);
    exp_len.push_back(16); exp_len.push_back(16);
    run_cmd(3'd2, '{err: 1'b0, code: 2'd0, steps: 3'd2}, lat);

    // Reset while waiting for the answer.
    setup(3'd0, M_NEVER, 0);
    @(negedge clk);
    cmd_target = 3'd1;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (lc_transition_request) seen = 1'b1;
    end
    check("reset_test_req_seen", int'(seen), 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_req", int'(lc_transition_request), 0);
    check_id("async_rst_identifier", lc_identifier, '0);
    check("async_rst_cmd_ready", int'(cmd_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", int'(cmd_ready), 1);
    check("post_rst_busy", int'(busy), 0);

    // Recovery after reset.
    setup(3'd2, M_ACCEPT, 1);
    exp_len.push_back(2);
    run_cmd(3'd3, '{err: 1'b0, code: 2'd0, steps: 3'd1}, lat);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("req_len_drained", exp_len.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
